prio_encoder_reg: RTL
=====================

PRIO_ENCODER_REG -- requirements
Module: prio_encoder_reg

Interface
REQ-001 Parameter N, default 8, meaning number of request inputs (legal 2..32).
REQ-002 Parameter W, default $clog2(N), meaning width of the encoded index.
REQ-003 Parameter RR_DEFAULT, default 0, meaning the mode value loaded at reset when mode_ld is never used.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 enable  input  1  grant enable; 0 blocks new grants and drops valid.
REQ-007 req  input  N  request lines, sampled every cycle.
REQ-008 mask  input  N  per-line mask; 1 excludes that line from selection.
REQ-009 mode  input  1  0 = fixed priority, 1 = round-robin.
REQ-010 mode_ld  input  1  1 loads mode into the internal mode register.
REQ-011 ack  input  1  consumer acknowledge of the current grant.
REQ-012 out  output  W  registered index of the granted line.
REQ-013 valid  output  1  registered flag; 1 = out holds a live grant.
REQ-014 pending  output  N  registered sticky pending vector.

Function
REQ-015 Pending: pending[i] sets on any edge with req[i]=1; it clears only on an edge with ack=1, valid=1, out=i and req[i]=0. Set wins over clear on the same edge.
REQ-016 Eligible vector: elig = pending & ~mask, evaluated from registered pending.
REQ-017 The state machine SHALL have two states, IDLE (valid=0) and GRANT (valid=1).
REQ-018 IDLE to GRANT: on an edge with enable=1 and elig!=0, the block loads out with the selected index and sets valid=1.
REQ-019 Latency: req[i] high at edge k gives pending[i] at k and valid/out at edge k+1, provided the block is in IDLE.
REQ-020 GRANT to IDLE: on an edge with ack=1, and on any edge with enable=0. No back-to-back grant on the ack edge; the minimum spacing between grants is 2 cycles.
REQ-021 In GRANT, out SHALL hold stable regardless of req or mask changes until the ack edge or the enable=0 edge.
REQ-022 ack while valid=0 SHALL be ignored, with no state change.
REQ-023 Fixed mode: select the highest-indexed set bit of elig (index N-1 is highest priority).
REQ-024 Round-robin mode: select the first set bit of elig, searching upward from ptr and wrapping from N-1 to 0.
REQ-025 ptr (W bits, internal) SHALL update only on an ack edge with valid=1, to (out+1) mod N, wrapping when out=N-1. ptr is kept but unused in fixed mode.
REQ-026 mode_ld=1 updates the mode register at the edge; the new mode applies to the next selection, and an outstanding grant is unaffected.
REQ-027 When enable=0, pending SHALL still accumulate requests, valid=0, and out holds its last value.
REQ-028 When elig=0 in IDLE, the block stays in IDLE with valid=0.

Reset
REQ-029 While rst_n=0, the following SHALL be forced immediately, independent of clk: out=0, valid=0, pending=0, ptr=0, mode register=RR_DEFAULT, state=IDLE.
REQ-030 Reset asserted mid-grant SHALL discard the grant and all pending requests; there is no restore after reset release.
REQ-031 The first grant after release SHALL be possible no earlier than the second rising edge with rst_n=1.

Verification (N=8)
REQ-032 Fixed mode, enable=1, a one-cycle pulse req=8'b0010_0100 -> next edge out=5, valid=1; after ack, out=2, valid=1; after ack, valid=0 and pending=0.
REQ-033 Round-robin mode, req held at 8'hFF, ack every cycle valid=1 -> grant sequence 0,1,2,…,7,0; this checks the wrap at N-1.
REQ-034 mask=8'h80 with req=8'h81 in fixed mode -> out=0; then mask=0 while valid=1 -> out stays 0 until ack, next grant out=7.
REQ-035 enable=0, req pulse 8'h10 -> valid stays 0 and pending=8'h10; raise enable -> next edge out=4, valid=1.
REQ-036 In GRANT out=3, apply ack and req[3]=1 on the same edge -> pending[3] stays 1, and line 3 is re-granted 2 cycles later in fixed mode when no higher line is pending.
REQ-037 Assert rst_n=0 asynchronously between edges while valid=1 -> valid, out and pending read 0 before the next clk edge.

Source files
------------

// File: rtl/prio_encoder_reg.sv
// prio_encoder_reg: registered fixed/round-robin priority encoder with sticky pending requests and an ack handshake
module prio_encoder_reg #(
  parameter int N = 8,
  parameter int W = $clog2(N),
  parameter bit RR_DEFAULT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         mode,
  input  logic         mode_ld,
  input  logic         ack,
  output logic [W-1:0] out,
  output logic         valid,
  output logic [N-1:0] pending
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic mode_r, done;
  logic [W-1:0] ptr, fix, sel;
  logic [W:0] sum;
  logic [N-1:0] elig, rot, clr;
  logic [2*N-1:0] dbl;
  assign valid = state == GRANT;
  assign done = valid & ack;
  assign elig = pending & ~mask;
  // rotate so bit 0 of rot is line ptr; the lowest set bit of rot is the round-robin winner
  assign dbl = {elig, elig} >> ptr;
  assign rot = dbl[N-1:0];
  always_comb begin
    fix = '0;
    sum = '0;
    clr = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) fix = W'(i);
      clr[i] = done && out == W'(i) && !req[i];
    end
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) sum = {1'b0, ptr} + (W+1)'(i);
    sel = mode_r ? (sum >= (W+1)'(N) ? W'(sum - (W+1)'(N)) : W'(sum)) : fix;
    state_n = state == IDLE ? ((enable && |elig) ? GRANT : IDLE) : ((ack || !enable) ? IDLE : GRANT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out <= '0;
      pending <= '0;
      ptr <= '0;
      mode_r <= RR_DEFAULT;
    end else begin
      state <= state_n;
      pending <= (pending & ~clr) | req;
      if (mode_ld) mode_r <= mode;
      if (done) ptr <= out == W'(N - 1) ? '0 : out + 1'b1;
      if (!valid && state_n == GRANT) out <= sel;
    end
  end
endmodule
